// File: rtl/vxc_pkg.sv
// Shared definitions for the vector-plus-constant-times-vector chunk feeder.
package vxc_pkg;

  localparam int ELEMENT_WIDTH_DEF = 32;
  localparam int NO_OF_UNITS_DEF   = 8;

  // Number of U-wide chunks needed to cover n elements (ceil divide).
  function automatic int vxc_chunks(input int n, input int u);
    return (n + u - 1) / u;
  endfunction

  // Element count after zero-padding the final chunk.
  function automatic int vxc_total(input int n, input int u);
    return vxc_chunks(n, u) * u;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } vxc_state_e;

endpackage

// File: rtl/vxc_lane_packer.sv
// One vector lane: U element slots, written one slot at a time by index,
// with an optional zero-fill instead of RAM data. Slot 0 is the MSB slot.
module vxc_lane_packer #(
  parameter int element_width = 32,
  parameter int no_of_units   = 8,
  parameter int slot_width    = 3
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   wr_en,
  input  logic [slot_width-1:0]                  wr_slot,
  input  logic                                   zero_fill,
  input  logic [element_width-1:0]               wr_data,
  output logic [element_width*no_of_units-1:0]   chunk
);

  logic [element_width-1:0] slot_q [no_of_units];
  logic [element_width-1:0] slot_d [no_of_units];

  // Next slot contents: at most one slot changes per cycle.
  always_comb begin
    slot_d = slot_q;
    if (wr_en && (int'(wr_slot) < no_of_units)) begin
      slot_d[wr_slot] = zero_fill ? '0 : wr_data;
    end
  end

  // Slot storage, cleared by the active-low synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < no_of_units; k++) slot_q[k] <= '0;
    end else begin
      for (int k = 0; k < no_of_units; k++) slot_q[k] <= slot_d[k];
    end
  end

  // Flatten slots onto the bus, element 0 in the most significant slot.
  always_comb begin
    chunk = '0;
    for (int k = 0; k < no_of_units; k++) begin
      chunk[element_width*(no_of_units-k)-1 -: element_width] = slot_q[k];
    end
  end

endmodule

// File: rtl/vxc_chunk_feeder.sv
// Streams two operand vectors out of synchronous-read RAMs and packs them
// into zero-padded U-element chunks for the downstream vXc stage.
//
// Chunk handshake: chunk_valid is raised only in PRESENT and stays high,
// with both buses and chunk_idx frozen, until a cycle in which chunk_ready
// is also high; that cycle is the transfer. chunk_ready has no effect while
// chunk_valid is low.
module vxc_chunk_feeder
  import vxc_pkg::*;
#(
  parameter int number_of_equations_per_cluster = 16,
  parameter int element_width                   = ELEMENT_WIDTH_DEF,
  parameter int no_of_units                     = NO_OF_UNITS_DEF,
  parameter int addr_width                      = 5
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  output logic                                 rd_en,
  output logic [addr_width-1:0]                rd_addr,
  input  logic [element_width-1:0]             vec1_rd_data,
  input  logic [element_width-1:0]             vec2_rd_data,
  output logic [element_width*no_of_units-1:0] first_row_plus_additional,
  output logic [element_width*no_of_units-1:0] second_row_plus_additional,
  output logic                                 chunk_valid,
  input  logic                                 chunk_ready,
  output logic [31:0]                          chunk_idx,
  output logic                                 busy,
  output logic                                 finish,
  output logic [2:0]                           dbg_state
);

  localparam int          SLOT_W  = (no_of_units > 1) ? $clog2(no_of_units) : 1;
  localparam logic [31:0] N_W     = 32'(number_of_equations_per_cluster);
  localparam logic [31:0] U_W     = 32'(no_of_units);
  localparam logic [31:0] TOTAL_W = 32'(vxc_total(number_of_equations_per_cluster, no_of_units));

  vxc_state_e        state_q, state_d;
  logic [31:0]       chunk_q, chunk_d;
  logic [31:0]       k_q, k_d;
  // A slot write scheduled for the cycle after its FETCH cycle; RAM data
  // arrives then, and padding slots use the same path with zero_fill set.
  logic              pend_q, pend_d;
  logic              pend_zero_q, pend_zero_d;
  logic [SLOT_W-1:0] pend_slot_q, pend_slot_d;

  logic [31:0]       elem;
  logic              last_chunk;
  logic              lane_wr_en;
  logic [element_width*no_of_units-1:0] lane1_chunk, lane2_chunk;

  assign elem       = chunk_q * U_W + k_q;
  assign last_chunk = (chunk_q * U_W + U_W) >= TOTAL_W;

  // Next-state, counters and control outputs.
  always_comb begin
    state_d     = state_q;
    chunk_d     = chunk_q;
    k_d         = k_q;
    pend_d      = 1'b0;
    pend_zero_d = 1'b0;
    pend_slot_d = pend_slot_q;
    rd_en       = 1'b0;
    rd_addr     = '0;
    chunk_valid = 1'b0;
    finish      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          chunk_d = '0;
          k_d     = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        pend_d      = 1'b1;
        pend_slot_d = k_q[SLOT_W-1:0];
        if (elem < N_W) begin
          rd_en   = 1'b1;
          rd_addr = elem[addr_width-1:0];
        end else begin
          pend_zero_d = 1'b1;
        end
        if (k_q == U_W - 32'd1) begin
          k_d     = '0;
          state_d = ST_CAPTURE;
        end else begin
          k_d = k_q + 32'd1;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        chunk_valid = 1'b1;
        if (chunk_ready) begin
          if (last_chunk) begin
            state_d = ST_DONE;
          end else begin
            chunk_d = chunk_q + 32'd1;
            k_d     = '0;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        finish  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and the pending slot write; reset drops any read in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      chunk_q     <= '0;
      k_q         <= '0;
      pend_q      <= 1'b0;
      pend_zero_q <= 1'b0;
      pend_slot_q <= '0;
    end else begin
      state_q     <= state_d;
      chunk_q     <= chunk_d;
      k_q         <= k_d;
      pend_q      <= pend_d;
      pend_zero_q <= pend_zero_d;
      pend_slot_q <= pend_slot_d;
    end
  end

  // Chunk registers only change in FETCH and CAPTURE.
  assign lane_wr_en = pend_q && ((state_q == ST_FETCH) || (state_q == ST_CAPTURE));

  vxc_lane_packer #(
    .element_width (element_width),
    .no_of_units   (no_of_units),
    .slot_width    (SLOT_W)
  ) u_lane1 (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (lane_wr_en),
    .wr_slot   (pend_slot_q),
    .zero_fill (pend_zero_q),
    .wr_data   (vec1_rd_data),
    .chunk     (lane1_chunk)
  );

  vxc_lane_packer #(
    .element_width (element_width),
    .no_of_units   (no_of_units),
    .slot_width    (SLOT_W)
  ) u_lane2 (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (lane_wr_en),
    .wr_slot   (pend_slot_q),
    .zero_fill (pend_zero_q),
    .wr_data   (vec2_rd_data),
    .chunk     (lane2_chunk)
  );

  // IDLE forces index and buses to zero so a finished run leaves nothing visible.
  assign busy                       = (state_q != ST_IDLE);
  assign chunk_idx                  = busy ? chunk_q : 32'd0;
  assign first_row_plus_additional  = busy ? lane1_chunk : '0;
  assign second_row_plus_additional = busy ? lane2_chunk : '0;
  assign dbg_state                  = 3'(state_q);

endmodule

// File: tb/tb_vxc_chunk_feeder.sv
// Bench for vxc_chunk_feeder: three instances (N=16, 12, 8 with U=8) driven
// one at a time, with RAM models, a chunk/address scoreboard and timing checks.
module tb_vxc_chunk_feeder;

  localparam int W  = 32;
  localparam int U  = 8;
  localparam int NI = 3;
  localparam int BW = W * U;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n [NI];
  logic          start [NI];
  logic          ready [NI];
  logic          rd_en [NI];
  logic [4:0]    rd_addr [NI];
  logic [W-1:0]  v1 [NI];
  logic [W-1:0]  v2 [NI];
  logic [BW-1:0] bus1 [NI];
  logic [BW-1:0] bus2 [NI];
  logic          chunk_valid [NI];
  logic [31:0]   idx [NI];
  logic          busy [NI];
  logic          finish [NI];
  logic [2:0]    dbg [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int NN = (g == 0) ? 16 : ((g == 1) ? 12 : 8);
    vxc_chunk_feeder #(
      .number_of_equations_per_cluster (NN),
      .element_width                   (W),
      .no_of_units                     (U),
      .addr_width                      (5)
    ) u_dut (
      .clk                        (clk),
      .reset                      (rst_n[g]),
      .start                      (start[g]),
      .rd_en                      (rd_en[g]),
      .rd_addr                    (rd_addr[g]),
      .vec1_rd_data               (v1[g]),
      .vec2_rd_data               (v2[g]),
      .first_row_plus_additional  (bus1[g]),
      .second_row_plus_additional (bus2[g]),
      .chunk_valid                (chunk_valid[g]),
      .chunk_ready                (ready[g]),
      .chunk_idx                  (idx[g]),
      .busy                       (busy[g]),
      .finish                     (finish[g]),
      .dbg_state                  (dbg[g])
    );
  end

  // RAM models: RAM1[i] = i, RAM2[i] = 0x100 + i; data one cycle after rd_en.
  // Old data is kept when rd_en is low so padding must really be zero-filled.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rd_en[i]) begin
        v1[i] <= 32'(rd_addr[i]);
        v2[i] <= 32'h100 + 32'(rd_addr[i]);
      end
    end
  end

  // ---------------- model and scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [4:0]    exp_addr_q [$];
  logic [BW-1:0] exp_b1_q [$];
  logic [BW-1:0] exp_b2_q [$];
  logic [31:0]   exp_idx_q [$];

  // Chunk c of a vector of n elements: element c*U+k in slot k (slot 0 = MSB),
  // zero beyond n.
  function automatic logic [BW-1:0] model_chunk(input int n, input int c, input bit second);
    logic [BW-1:0] r;
    r = '0;
    for (int k = 0; k < U; k++) begin
      int e;
      e = c * U + k;
      if (e < n) r[W*(U-k)-1 -: W] = second ? (32'h100 + 32'(e)) : 32'(e);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [BW-1:0] act_v, input logic [BW-1:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act_v, exp_v);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  // ---------------- compare process ----------------
  int            cyc = 0;
  bit            chk_en = 1'b0;
  int            act = 0;
  int            start_cyc, first_rd_cyc, first_valid_cyc, finish_cyc, accept_cyc;
  int            finish_cnt, accept_cnt, rd_cnt, stall_cnt;
  bit            pending;
  logic [BW-1:0] acc1 [2];
  logic [BW-1:0] acc2 [2];

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        check("finish_with_valid", {255'b0, finish[i] & chunk_valid[i]}, '0);
        if (!busy[i]) begin
          check("idle_ctrl", {216'b0, rd_en[i], rd_addr[i], chunk_valid[i], finish[i], idx[i]}, '0);
          check("idle_bus", bus1[i] | bus2[i], '0);
        end
        if (i != act) check("inactive_busy", {255'b0, busy[i]}, '0);
      end
      if (start[act] && !busy[act]) start_cyc = cyc;
      check("rd_during_present", {255'b0, rd_en[act] & pending}, '0);
      if (rd_en[act]) begin
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        rd_cnt++;
        if (exp_addr_q.size() == 0) fail("unexpected_read");
        else check("rd_addr", {251'b0, rd_addr[act]}, {251'b0, exp_addr_q.pop_front()});
      end
      if (chunk_valid[act]) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        pending = 1'b1;
        if (exp_b1_q.size() == 0) begin
          fail("unexpected_chunk");
        end else begin
          check("bus1", bus1[act], exp_b1_q[0]);
          check("bus2", bus2[act], exp_b2_q[0]);
          check("chunk_idx", {224'b0, idx[act]}, {224'b0, exp_idx_q[0]});
          if (ready[act]) begin
            acc1[idx[act][0]] = bus1[act];
            acc2[idx[act][0]] = bus2[act];
            void'(exp_b1_q.pop_front());
            void'(exp_b2_q.pop_front());
            void'(exp_idx_q.pop_front());
            accept_cnt++;
            accept_cyc = cyc;
            pending    = 1'b0;
          end else begin
            stall_cnt++;
          end
        end
      end else if (pending) begin
        fail("valid_dropped");
        pending = 1'b0;
      end
      if (finish[act]) begin
        finish_cnt++;
        finish_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic setup(input int inst, input int n);
    act = inst;
    exp_addr_q.delete();
    exp_b1_q.delete();
    exp_b2_q.delete();
    exp_idx_q.delete();
    for (int a = 0; a < n; a++) exp_addr_q.push_back(5'(a));
    for (int c = 0; c < (n + U - 1) / U; c++) begin
      exp_b1_q.push_back(model_chunk(n, c, 1'b0));
      exp_b2_q.push_back(model_chunk(n, c, 1'b1));
      exp_idx_q.push_back(32'(c));
    end
    start_cyc = -1; first_rd_cyc = -1; first_valid_cyc = -1;
    finish_cyc = -1; accept_cyc = -1;
    finish_cnt = 0; accept_cnt = 0; rd_cnt = 0; stall_cnt = 0;
    pending = 1'b0;
  endtask

  task automatic pulse_start(input int inst);
    @(posedge clk); #1 start[inst] = 1'b1;
    @(posedge clk); #1 start[inst] = 1'b0;
  endtask

  task automatic wait_finish(input int max_cycles);
    int t;
    t = 0;
    while (finish_cnt == 0 && t < max_cycles) begin
      @(posedge clk);
      t++;
    end
    if (finish_cnt == 0) fail("finish_timeout");
  endtask

  task automatic wait_first_valid(input int max_cycles);
    int t;
    t = 0;
    while (first_valid_cyc < 0 && t < max_cycles) begin
      @(posedge clk);
      t++;
    end
    if (first_valid_cyc < 0) fail("valid_timeout");
  endtask

  task automatic end_of_run(input string tag, input int exp_chunks);
    repeat (4) @(posedge clk);
    check({tag, "_addr_left"}, 256'(exp_addr_q.size()), '0);
    check({tag, "_chunks_left"}, 256'(exp_b1_q.size()), '0);
    check({tag, "_finish_cnt"}, 256'(finish_cnt), 256'd1);
    check({tag, "_accept_cnt"}, 256'(accept_cnt), 256'(exp_chunks));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0; start[i] = 1'b0; ready[i] = 1'b0;
    end
    setup(0, 16);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("reset_state", {253'b0, dbg[i]}, '0);
      check("reset_busy", {255'b0, busy[i]}, '0);
    end

    // N=16, ready held high throughout.
    setup(0, 16);
    ready[0] = 1'b1;
    pulse_start(0);
    wait_finish(100);
    end_of_run("n16", 2);
    check("n16_first_rd", 256'(first_rd_cyc - start_cyc), 256'd1);
    check("n16_first_valid", 256'(first_valid_cyc - start_cyc), 256'd10);
    check("n16_finish_cyc", 256'(finish_cyc - start_cyc), 256'd21);
    check("n16_rd_cnt", 256'(rd_cnt), 256'd16);
    check("n16_c0_msb1", 256'(acc1[0][255:224]), 256'd0);
    check("n16_c0_lsb1", 256'(acc1[0][31:0]), 256'd7);
    check("n16_c0_msb2", 256'(acc2[0][255:224]), 256'h100);
    check("n16_c0_lsb2", 256'(acc2[0][31:0]), 256'h107);
    check("n16_c1_msb1", 256'(acc1[1][255:224]), 256'd8);
    check("n16_c1_lsb1", 256'(acc1[1][31:0]), 256'd15);

    // N=12: second chunk padded with zeros, no reads past address 11.
    setup(1, 12);
    ready[1] = 1'b1;
    pulse_start(1);
    wait_finish(100);
    end_of_run("n12", 2);
    check("n12_rd_cnt", 256'(rd_cnt), 256'd12);
    check("n12_finish_cyc", 256'(finish_cyc - start_cyc), 256'd21);
    check("n12_c1_slot0", 256'(acc1[1][255:224]), 256'd8);
    check("n12_c1_slot3", 256'(acc1[1][159:128]), 256'd11);
    check("n12_c1_slot3b", 256'(acc2[1][159:128]), 256'h10b);
    check("n12_c1_slot4", 256'(acc1[1][127:96]), 256'd0);
    check("n12_c1_slot7b", 256'(acc2[1][31:0]), 256'd0);
    ready[1] = 1'b0;

    // Backpressure: chunk 0 held for extra cycles.
    setup(0, 16);
    ready[0] = 1'b0;
    pulse_start(0);
    wait_first_valid(50);
    repeat (5) @(posedge clk);
    #1 ready[0] = 1'b1;
    wait_finish(100);
    end_of_run("bp", 2);
    check("bp_stall_cnt", 256'(stall_cnt), 256'd6);
    check("bp_finish_cyc", 256'(finish_cyc - start_cyc), 256'd27);

    // Reset during FETCH of chunk 1, then a clean restart.
    setup(0, 16);
    ready[0] = 1'b1;
    pulse_start(0);
    t = 0;
    while (accept_cnt == 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    if (accept_cnt == 0) fail("rst_accept_timeout");
    @(posedge clk);
    #1 rst_n[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_busy", {255'b0, busy[0]}, '0);
    check("rst_ctrl", {216'b0, rd_en[0], rd_addr[0], chunk_valid[0], finish[0], idx[0]}, '0);
    check("rst_bus", bus1[0] | bus2[0], '0);
    setup(0, 16);
    @(posedge clk);
    #1 rst_n[0] = 1'b1;
    pulse_start(0);
    wait_finish(100);
    end_of_run("rst", 2);
    check("rst_finish_cyc", 256'(finish_cyc - start_cyc), 256'd21);

    // start pulses while busy must be ignored.
    setup(0, 16);
    ready[0] = 1'b1;
    pulse_start(0);
    repeat (2) @(posedge clk);
    pulse_start(0);
    repeat (4) @(posedge clk);
    pulse_start(0);
    repeat (8) @(posedge clk);
    pulse_start(0);
    wait_finish(100);
    repeat (10) @(posedge clk);
    end_of_run("busy_start", 2);
    check("busy_start_finish_cyc", 256'(finish_cyc - start_cyc), 256'd21);
    check("busy_start_idle", {255'b0, busy[0]}, '0);
    ready[0] = 1'b0;

    // N=8: single chunk, late acceptance.
    setup(2, 8);
    ready[2] = 1'b0;
    pulse_start(2);
    wait_first_valid(50);
    repeat (2) @(posedge clk);
    #1 ready[2] = 1'b1;
    wait_finish(100);
    end_of_run("n8", 1);
    check("n8_first_valid", 256'(first_valid_cyc - start_cyc), 256'd10);
    check("n8_finish_after_accept", 256'(finish_cyc - accept_cyc), 256'd1);
    check("n8_c0_msb", 256'(acc1[0][255:224]), 256'd0);
    check("n8_c0_lsb", 256'(acc2[0][31:0]), 256'h107);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
